ddr_burst_scheduler: RTL

- Sequences and shares the single AXI4 master port of the stereo frame buffer between two requesters.
- Write requester: the camera-1 write FIFO (data into DDR). Read requester: the read-back FIFO feeding the synchronized video1 output stream.
- Decides which burst (write or read) goes next and generates its DDR address, with per-frame restart and wrap at frame size.
- Tracks outstanding bursts so the read FIFO can never overflow and the interconnect issuing limit is never exceeded.

---
 rtl/ddr_burst_scheduler_if.sv | 22 ++
 rtl/ddr_burst_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ddr_burst_scheduler_if.sv
// Burst command channel between the DDR burst scheduler and the AXI address/response logic.
interface ddr_burst_scheduler_if #(
   parameter int unsigned ADDR_WIDTH = 49
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [7:0]            cmd_len;
   logic                  wr_done;
   logic                  rd_done;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_len,
      input  cmd_ready, wr_done, rd_done
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len,
      output cmd_ready, wr_done, rd_done
   );
endinterface

// File: rtl/ddr_burst_scheduler.sv
// Shares one AXI4 master between the camera write FIFO and the video read-back FIFO:
// arbitrates bursts, generates per-frame wrapping addresses and bounds in-flight bursts.
module ddr_burst_scheduler #(
   parameter int unsigned ADDR_WIDTH      = 49,
   parameter logic [63:0] BASE_ADDR       = 64'd0,
   parameter int unsigned FRAME_BYTES     = 33177600,
   parameter int unsigned BURST_BEATS     = 16,
   parameter int unsigned BEAT_BYTES      = 16,
   parameter int unsigned COUNT_WIDTH     = 12,
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter int unsigned HIGH_WATER      = 1024
) (
   input  logic                   ACLK,
   input  logic                   ARESETN,
   input  logic [COUNT_WIDTH-1:0] wr_fifo_count,
   input  logic [COUNT_WIDTH-1:0] rd_fifo_space,
   input  logic                   frame_start_wr,
   input  logic                   frame_start_rd,
   ddr_burst_scheduler_if.master  bus,
   output logic [1:0]             state,
   output logic                   err
);

   localparam int unsigned BURST_BYTES = BURST_BEATS * BEAT_BYTES;
   localparam int unsigned OFF_W       = $clog2(FRAME_BYTES + 1);
   localparam int unsigned OUT_W       = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned NEED_W      = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARB   = 2'd1,
      ST_ISSUE = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               wr_armed, rd_armed;
   logic [OFF_W-1:0]   wr_offset, rd_offset;
   logic [OUT_W-1:0]   wr_out, rd_out;
   logic               last_grant_wr;
   logic               wr_restart, rd_restart;

   logic               wr_elig_c, rd_elig_c, grant_wr_c, accept_c;
   logic [NEED_W-1:0]  rd_need_c;

   function automatic logic [OFF_W-1:0] advance(input logic [OFF_W-1:0] off);
      logic [OFF_W:0] nxt;
      nxt = (OFF_W+1)'(off) + (OFF_W+1)'(BURST_BYTES);
      return (nxt == (OFF_W+1)'(FRAME_BYTES)) ? '0 : OFF_W'(nxt);
   endfunction

   // Accept and done together cancel; a done with nothing in flight leaves the count at zero.
   function automatic logic [OUT_W-1:0] next_out(input logic [OUT_W-1:0] cur,
                                                  input logic inc, input logic dec);
      if (inc && !dec)               return cur + OUT_W'(1);
      if (dec && !inc && cur != '0)  return cur - OUT_W'(1);
      return cur;
   endfunction

   // Read eligibility reserves FIFO space for every read already in flight.
   always_comb begin
      rd_need_c  = NEED_W'(BURST_BEATS) * (NEED_W'(rd_out) + NEED_W'(1));
      wr_elig_c  = wr_armed && (wr_fifo_count >= COUNT_WIDTH'(BURST_BEATS))
                   && (wr_out < OUT_W'(MAX_OUTSTANDING));
      rd_elig_c  = rd_armed && (NEED_W'(rd_fifo_space) >= rd_need_c)
                   && (rd_out < OUT_W'(MAX_OUTSTANDING));
      grant_wr_c = 1'b0;
      if (wr_elig_c && (wr_fifo_count >= COUNT_WIDTH'(HIGH_WATER)))
         grant_wr_c = 1'b1;
      else if (wr_elig_c && !rd_elig_c)
         grant_wr_c = 1'b1;
      else if (wr_elig_c && rd_elig_c)
         grant_wr_c = !last_grant_wr;
      accept_c = bus.cmd_valid && bus.cmd_ready;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (wr_armed || rd_armed)   state_d = ST_ARB;
         ST_ARB:   if (wr_elig_c || rd_elig_c) state_d = ST_ISSUE;
         ST_ISSUE: if (accept_c)               state_d = ST_HOLD;
         ST_HOLD:                              state_d = ST_ARB;
         default:                              state_d = ST_IDLE;
      endcase
   end

   assign state = state_q;

   // Command register, offsets, outstanding counters and sticky error.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         bus.cmd_valid <= 1'b0;
         bus.cmd_write <= 1'b0;
         bus.cmd_addr  <= ADDR_WIDTH'(BASE_ADDR);
         bus.cmd_len   <= 8'(BURST_BEATS - 1);
         err           <= 1'b0;
         wr_armed      <= 1'b0;
         rd_armed      <= 1'b0;
         wr_offset     <= '0;
         rd_offset     <= '0;
         wr_out        <= '0;
         rd_out        <= '0;
         last_grant_wr <= 1'b0;
         wr_restart    <= 1'b0;
         rd_restart    <= 1'b0;
      end else begin
         bus.cmd_valid <= (state_d == ST_ISSUE);
         if ((state_q == ST_ARB) && (wr_elig_c || rd_elig_c)) begin
            bus.cmd_write <= grant_wr_c;
            bus.cmd_addr  <= ADDR_WIDTH'(BASE_ADDR)
                             + ADDR_WIDTH'(grant_wr_c ? wr_offset : rd_offset);
         end

         wr_armed <= wr_armed || frame_start_wr;
         rd_armed <= rd_armed || frame_start_rd;

         // A frame start seen while a command waits discards that command's offset advance.
         if (accept_c)                                      wr_restart <= 1'b0;
         else if (frame_start_wr && (state_q == ST_ISSUE))  wr_restart <= 1'b1;
         if (accept_c)                                      rd_restart <= 1'b0;
         else if (frame_start_rd && (state_q == ST_ISSUE))  rd_restart <= 1'b1;

         if (frame_start_wr)
            wr_offset <= '0;
         else if (accept_c && bus.cmd_write)
            wr_offset <= wr_restart ? '0 : advance(wr_offset);
         if (frame_start_rd)
            rd_offset <= '0;
         else if (accept_c && !bus.cmd_write)
            rd_offset <= rd_restart ? '0 : advance(rd_offset);

         if (accept_c) last_grant_wr <= bus.cmd_write;

         wr_out <= next_out(wr_out, accept_c && bus.cmd_write, bus.wr_done);
         rd_out <= next_out(rd_out, accept_c && !bus.cmd_write, bus.rd_done);

         if ((bus.wr_done && (wr_out == '0)) || (bus.rd_done && (rd_out == '0)))
            err <= 1'b1;
      end
   end

endmodule
